// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the byte-stream program loader.
package loader_pkg;

  localparam logic [7:0]  HEADER_BYTE      = 8'hA5;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h6800_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    FILL  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// Collects big-endian bytes into 32-bit words; word_valid_c marks the byte that completes a word.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_c,
  output logic        word_valid_c
);

  logic [23:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (byte_valid_i) begin
      sr_d  = {sr_q[15:0], byte_i};
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // The first byte received ends up in bits [31:24].
  assign word_c       = {sr_q, byte_i};
  assign word_valid_c = byte_valid_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Receives a framed program over a byte stream, writes it into instruction memory,
// pads the rest with NOPs and releases the core only after a verified load.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  widx_q, widx_d;
  logic [CNT_W-1:0]  widx_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              core_reset_q, core_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [31:0]       word_c;
  logic              word_valid_c;

  assign accept   = rx_valid && ready_q;
  assign widx_inc = widx_q + CNT_W'(1);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (state_q != DATA),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_i       (rx_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (accept && (rx_data == HEADER_BYTE)) begin
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (accept) begin
          if ((rx_data == 8'd0) || ({24'd0, rx_data} > DEPTH)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
            cnt_d   = CNT_W'(rx_data);
            widx_d  = '0;
            csum_d  = '0;
          end
        end
      end

      DATA: begin
        if (we_q) begin
          // Write cycle: advance to the next word slot, no byte taken.
          widx_d = widx_inc;
          if (widx_inc == cnt_q) begin
            state_d = CSUM;
          end
        end else if (accept) begin
          csum_d = csum_q + rx_data;
          if (word_valid_c) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = word_c;
          end
        end
      end

      CSUM: begin
        if (accept) begin
          if (rx_data != csum_q) begin
            state_d = ERR;
          end else if (cnt_q == CNT_W'(DEPTH)) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = NOP_WORD;
          end
        end
      end

      FILL: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          we_d    = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          wdata_d = NOP_WORD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d      = !we_d && (state_d != FILL);
    core_reset_d = (state_d != DONE);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      widx_q       <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random-gap byte frames checked against a frame-level memory image model.
module tb_program_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;
  localparam logic [31:0] NOP    = 32'h6800_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  logic [31:0] dut_img [DEPTH];
  logic [31:0] exp_img [DEPTH];
  logic [7:0]  frame [$];
  logic [31:0] prime [$];
  logic [31:0] words [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory-side observer: every write lands in the bench's copy of the instruction memory.
  always @(negedge clk) begin
    if (imem_we) begin
      dut_img[imem_addr] = imem_wdata;
      wr_count++;
      check("ready_during_we", 32'(rx_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int k;
    gap = int'($urandom_range(0, 3));
    k = 0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic build_frame(input logic [31:0] wq[$], input int n, input int cs_delta);
    int s;
    logic [31:0] w;
    s = 0;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(8'(n));
    for (int k = 0; k < wq.size(); k++) begin
      w = wq[k];
      for (int b = 3; b >= 0; b--) begin
        frame.push_back(w[8*b +: 8]);
        s += int'(w[8*b +: 8]);
      end
    end
    frame.push_back(8'(s + cs_delta));
  endtask

  // Frame-level reference: parse the byte list and update the expected memory image.
  task automatic model_frame(output int exp_wr, output bit exp_done, output bit exp_err);
    int i;
    int n;
    int total;
    exp_wr = 0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    total = 0;
    i = 0;
    while (i < frame.size() && frame[i] != 8'hA5) i++;
    i++;
    n = int'(frame[i]);
    i++;
    if (n == 0 || n > int'(DEPTH)) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_img[k] = {frame[i], frame[i+1], frame[i+2], frame[i+3]};
      total += int'(frame[i]) + int'(frame[i+1]) + int'(frame[i+2]) + int'(frame[i+3]);
      exp_wr++;
      i += 4;
    end
    if ((total % 256) == int'(frame[i])) begin
      for (int a = n; a < int'(DEPTH); a++) begin
        exp_img[a] = NOP;
        exp_wr++;
      end
      exp_done = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic run_frame(input string tag);
    int exp_wr;
    bit ed;
    bit ee;
    bit seen_hdr;
    int k;
    model_frame(exp_wr, ed, ee);
    wr_count = 0;
    seen_hdr = 1'b0;
    k = 0;
    foreach (frame[j]) begin
      send_byte(frame[j]);
      if (!seen_hdr && frame[j] == 8'hA5) begin
        seen_hdr = 1'b1;
        check({tag, "_hdr_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_hdr_done"}, 32'(done), 32'd0);
        check({tag, "_hdr_err"}, 32'(err), 32'd0);
      end
    end
    while (!(done || err) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_finished"}, 32'(done || err), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(ed));
    check({tag, "_err"}, 32'(err), 32'(ee));
    check({tag, "_core_reset"}, 32'(core_reset), 32'(!ed));
    check({tag, "_writes"}, 32'(wr_count), 32'(exp_wr));
    for (int a = 0; a < int'(DEPTH); a++) begin
      check($sformatf("%s_img%0d", tag, a), dut_img[a], exp_img[a]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int snap;
    int n;
    int delta;

    prime = {32'h4C800002, 32'h4C400003, 32'h10420000, 32'h20830001, 32'h3104FFFF,
             32'h58A00004, 32'h08C60001, 32'h4C000007, 32'h18E70000, 32'h29080002,
             32'h60000003, 32'h39290001, 32'h4C80000B, 32'h114A0000, 32'h58000010,
             32'h70000000, 32'h68000000};
    for (int a = 0; a < int'(DEPTH); a++) begin
      dut_img[a] = '0;
      exp_img[a] = '0;
    end

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    build_frame(prime, 17, 0);
    run_frame("prime");
    check("prime_addr0", exp_img[0], 32'h4C800002);

    build_frame(prime, 17, 1);
    run_frame("bad_csum");

    words.delete();
    build_frame(words, 0, 0);
    run_frame("count_zero");
    build_frame(words, 8'h41, 0);
    run_frame("count_big");

    build_frame(prime, 17, 0);
    frame.push_front(8'h13);
    frame.push_front(8'h00);
    run_frame("junk_lead");

    // Abort partway through a frame: header, count, then six data bytes.
    build_frame(prime, 17, 0);
    wr_count = 0;
    for (int j = 0; j < 8; j++) send_byte(frame[j]);
    check("abort_pre_writes", 32'(wr_count), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("abort");
    snap = wr_count;
    repeat (3) @(negedge clk);
    check("abort_no_writes", 32'(wr_count), 32'(snap));
    reset = 1'b0;
    @(negedge clk);
    exp_img[0] = prime[0];
    run_frame("reload");

    words.delete();
    words.push_back(32'h4C000001);
    build_frame(words, 1, 0);
    run_frame("one_word");

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 64));
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
      delta = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0;
      build_frame(words, n, delta);
      run_frame($sformatf("rand%0d", r));
    end

    words.delete();
    for (int k = 0; k < int'(DEPTH); k++) words.push_back($urandom);
    build_frame(words, int'(DEPTH), 0);
    run_frame("full_depth");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
